// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: instruction-queue depth and the {pc, inst} packet layout.
package rv32i_types;

  localparam int unsigned IQ_DEPTH = 16;

  // Field order gives pc in [63:32] and inst in [31:0] when the struct is packed.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_packet_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/decode-facing signal bundle of the instruction queue.
interface inst_queue_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64
);

  logic                     branch_mispredict;
  logic                     enq_valid;
  logic [WIDTH-1:0]         enq_packet;
  logic                     enq_ready;
  logic                     deq_ready;
  logic                     valid_inst;
  logic [WIDTH-1:0]         queue_packet;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;

  // Environment side: fetch, decode and the ROB flush source.
  modport master (
    output branch_mispredict, enq_valid, enq_packet, deq_ready,
    input  enq_ready, valid_inst, queue_packet, full, empty, count
  );

  // Queue side.
  modport slave (
    input  branch_mispredict, enq_valid, enq_packet, deq_ready,
    output enq_ready, valid_inst, queue_packet, full, empty, count
  );

endinterface

// File: rtl/inst_queue.sv
// Circular fetch-to-decode instruction buffer; pointers carry an extra wrap bit so that
// full and empty are distinguishable. A branch mispredict flushes every entry.
module inst_queue
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned WIDTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  inst_queue_if.slave  q
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    r_head_ptr;
  logic [PW-1:0]    r_tail_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0]    w_head_idx;
  logic [AW-1:0]    w_tail_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_enq_fire;
  logic             w_deq_fire;

  assign w_head_idx = r_head_ptr[AW-1:0];
  assign w_tail_idx = r_tail_ptr[AW-1:0];

  assign w_empty = (r_head_ptr == r_tail_ptr);
  assign w_full  = (w_head_idx == w_tail_idx) && (r_head_ptr[AW] != r_tail_ptr[AW]);

  // Flush wins over both handshakes; enq_ready depends only on registered state.
  assign w_enq_fire = q.enq_valid && !w_full  && !q.branch_mispredict;
  assign w_deq_fire = q.deq_ready && !w_empty && !q.branch_mispredict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_ptr <= '0;
      r_tail_ptr <= '0;
    end else if (q.branch_mispredict) begin
      r_head_ptr <= '0;
      r_tail_ptr <= '0;
    end else begin
      if (w_enq_fire) r_tail_ptr <= r_tail_ptr + PW'(1);
      if (w_deq_fire) r_head_ptr <= r_head_ptr + PW'(1);
    end
  end

  // Storage is intentionally not reset; the pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (w_enq_fire) r_mem[w_tail_idx] <= q.enq_packet;
  end

  assign q.full         = w_full;
  assign q.empty        = w_empty;
  assign q.enq_ready    = ~w_full;
  assign q.valid_inst   = ~w_empty;
  assign q.count        = r_tail_ptr - r_head_ptr;
  assign q.queue_packet = w_empty ? '0 : r_mem[w_head_idx];

endmodule
